dlfloat_result_collector: RTL and testbench

DLFLOAT_RESULT_COLLECTOR -- requirements
Module: dlfloat_result_collector

---
 rtl/dlfloat_result_collector.sv | 152 +++++++++++++++
 tb/tb_dlfloat_result_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_result_collector.sv
// dlfloat_result_collector
// Reassembles serialized DLFloat results (MSB byte, then LSB byte) into
// 16-bit words and queues them in a first-word fall-through FIFO.
// Optional build macro: DLFLOAT_RESULT_CLASSIFY_EN enables head-word
// classification on res_class (zero / all-ones special); otherwise res_class = 0.
//
// Handshake: a word leaves the FIFO on a rising edge where
// res_valid && res_ready. res_data is stable while res_valid is high and
// res_ready is low. res_valid never depends on res_ready.
module dlfloat_result_collector #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_en,
  input  logic                       align,
  output logic [15:0]                res_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       desync,
  input  logic                       clr_flags,
  output logic [1:0]                 res_class
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_ALIGN = 2'd0,
    GET_MSB    = 2'd1,
    GET_LSB    = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [7:0]    msb, msb_next;
  logic          push;
  logic          desync_set;
  logic [15:0]   push_word;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, push_ok, overflow_set;

  // Byte assembler: decides MSB capture, word push and desync events
  always_comb begin
    state_next = state;
    msb_next   = msb;
    push       = 1'b0;
    desync_set = 1'b0;
    if (byte_en) begin
      case (state)
        WAIT_ALIGN: begin
          if (align) begin
            msb_next   = byte_in;
            state_next = GET_LSB;
          end
        end
        GET_MSB: begin
          msb_next   = byte_in;
          state_next = GET_LSB;
        end
        GET_LSB: begin
          if (align) begin
            // A new frame start while an LSB is expected: drop old MSB
            msb_next   = byte_in;
            desync_set = 1'b1;
          end else begin
            push       = 1'b1;
            state_next = GET_MSB;
          end
        end
        default: state_next = WAIT_ALIGN;
      endcase
    end
  end

  assign push_word = {msb, byte_in};

  // Assembler state and captured MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_ALIGN;
      msb   <= 8'h00;
    end else begin
      state <= state_next;
      msb   <= msb_next;
    end
  end

  assign full         = (level == LW'(DEPTH));
  assign res_valid    = (level != '0);
  assign pop          = res_valid && res_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push_ok      = push && (!full || pop);
  assign overflow_set = push && full && !pop;

  // FIFO storage; contents are don't-care outside the valid window
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky flags; a set event in the clearing cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      desync   <= 1'b0;
    end else begin
      if (overflow_set)   overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (desync_set)     desync   <= 1'b1;
      else if (clr_flags) desync   <= 1'b0;
    end
  end

  assign res_data   = res_valid ? mem[rd_ptr] : 16'h0000;
  assign fifo_level = level;

`ifdef DLFLOAT_RESULT_CLASSIFY_EN
  // Head-word class: 01 zero, 10 all-ones special, 00 otherwise or empty
  always_comb begin
    res_class = 2'b00;
    if (res_valid) begin
      if (res_data == 16'h0000)      res_class = 2'b01;
      else if (res_data == 16'hFFFF) res_class = 2'b10;
    end
  end
`else
  assign res_class = 2'b00;
`endif

endmodule

// File: tb/tb_dlfloat_result_collector.sv
// Bench for dlfloat_result_collector: directed scenarios with literal
// expectations plus randomized traffic compared against a queue model.
module tb_dlfloat_result_collector;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef DLFLOAT_RESULT_CLASSIFY_EN
  localparam bit CLASSIFY = 1'b1;
`else
  localparam bit CLASSIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_en = 1'b0;
  logic          align = 1'b0;
  logic [15:0]   res_data;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          desync;
  logic          clr_flags = 1'b0;
  logic [1:0]    res_class;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  dlfloat_result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_en(byte_en),
    .align(align), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .fifo_level(fifo_level), .overflow(overflow),
    .desync(desync), .clr_flags(clr_flags), .res_class(res_class)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  bit          m_aligned;   // a frame start has been seen since reset
  bit          m_have_msb;  // an MSB is waiting for its LSB
  logic [7:0]  m_msb;
  bit          m_ovf, m_des;

  always @(posedge clk) begin
    bit do_pop, do_push, ovf_set, des_set;
    logic [15:0] w;
    if (rst) begin
      exp_q.delete();
      m_aligned = 0; m_have_msb = 0; m_msb = 8'h00; m_ovf = 0; m_des = 0;
    end else begin
      do_pop  = (exp_q.size() > 0) && res_ready;
      do_push = 0; ovf_set = 0; des_set = 0; w = 16'h0000;
      if (byte_en) begin
        if (align) begin
          if (m_have_msb) des_set = 1;
          m_msb = byte_in; m_have_msb = 1; m_aligned = 1;
        end else if (m_aligned) begin
          if (m_have_msb) begin
            w = {m_msb, byte_in}; do_push = 1; m_have_msb = 0;
          end else begin
            m_msb = byte_in; m_have_msb = 1;
          end
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else ovf_set = 1;
      end
      m_ovf = ovf_set ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
      m_des = des_set ? 1'b1 : (clr_flags ? 1'b0 : m_des);
    end
  end

  function automatic logic [1:0] class_of(logic [15:0] w, bit valid);
    if (!CLASSIFY || !valid) return 2'b00;
    if (w == 16'h0000) return 2'b01;
    if (w == 16'hFFFF) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] hd;
    bit v;
    if (chk_en) begin
      v  = exp_q.size() > 0;
      hd = v ? exp_q[0] : 16'h0000;
      chk("cmp_valid", 32'(res_valid), 32'(v));
      chk("cmp_data", 32'(res_data), 32'(hd));
      chk("cmp_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
      chk("cmp_desync", 32'(desync), 32'(m_des));
      chk("cmp_class", 32'(res_class), 32'(class_of(hd, v)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(logic [7:0] b, logic a);
    byte_in = b; byte_en = 1'b1; align = a;
    tick();
    byte_en = 1'b0; align = 1'b0;
  endtask

  task automatic send_word(logic [15:0] w);
    send(w[15:8], 1'b1);
    send(w[7:0], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_data"}, 32'(res_data), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_des"}, 32'(desync), 32'd0);
    chk({tag, "_class"}, 32'(res_class), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    do_reset();
    chk_en = 1'b1;
    chk_idle_outputs("reset");

    // Basic word assembly and fall-through latency
    send(8'h3E, 1'b1);
    chk("msb_only_valid", 32'(res_valid), 32'd0);
    send(8'h40, 1'b0);
    chk("word_valid", 32'(res_valid), 32'd1);
    chk("word_data", 32'(res_data), 32'h3E40);
    chk("word_level", 32'(fifo_level), 32'd1);

    // Unaligned bytes after reset are ignored
    do_reset();
    send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0);
    chk("unaligned_valid", 32'(res_valid), 32'd0);
    send_word(16'h789A);
    chk("after_align_data", 32'(res_data), 32'h789A);

    // Overflow and full-with-pop
    do_reset();
    res_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_word(16'((k << 12) | (k << 8) | (k << 4) | k));
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_head", 32'(res_data), 32'h1111);
    send(8'hAB, 1'b1);
    res_ready = 1'b1;
    send(8'hCD, 1'b0);
    res_ready = 1'b0;
    chk("pushpop_level", 32'(fifo_level), 32'd4);
    chk("pushpop_ovf", 32'(overflow), 32'd1);
    chk("pushpop_head", 32'(res_data), 32'h2222);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Desync on early align
    do_reset();
    send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'hCC, 1'b0);
    chk("desync_set", 32'(desync), 32'd1);
    chk("desync_word", 32'(res_data), 32'hBBCC);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("desync_clr", 32'(desync), 32'd0);

    // Classification of popped heads
    do_reset();
    send_word(16'hFFFF); send_word(16'h0000); send_word(16'h4200);
    chk("class_ffff", 32'(res_class), CLASSIFY ? 32'd2 : 32'd0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("class_zero", 32'(res_class), CLASSIFY ? 32'd1 : 32'd0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("class_other", 32'(res_class), 32'd0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("class_empty", 32'(res_class), 32'd0);
    chk("empty_after_pops", 32'(res_valid), 32'd0);

    // Reset mid-word with stored data
    do_reset();
    send_word(16'h1357); send_word(16'h2468); send(8'h77, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_idle_outputs("midreset");
    send(8'h88, 1'b0); send(8'h99, 1'b0);
    chk("midreset_ignored", 32'(res_valid), 32'd0);
    send(8'h88, 1'b1); send(8'h99, 1'b0);
    chk("midreset_word", 32'(res_data), 32'h8899);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: b = 8'h00;
        1: b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      byte_in   = b;
      byte_en   = ($urandom_range(0, 3) != 0);
      align     = ($urandom_range(0, 5) == 0);
      res_ready = ($urandom_range(0, 2) == 0);
      clr_flags = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    byte_en = 1'b0; align = 1'b0; res_ready = 1'b0; clr_flags = 1'b0; rst = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
